// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: shares the single-port 64-bit main memory between the host command engine
// and the compute sequencer. Optional performance counters are built when MLACCEL_MEMARB_PERF_EN is defined.
module mlaccel_memarb #(
  parameter int COMP_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [15:0] host_addr,
  input  logic [63:0] host_wdata,
  input  logic [7:0]  host_wtags,
  output logic        host_done,
  output logic [63:0] host_rdata,
  input  logic        comp_valid,
  output logic        comp_ready,
  input  logic        comp_write,
  input  logic [15:0] comp_addr,
  input  logic [63:0] comp_wdata,
  input  logic [7:0]  comp_wen,
  output logic        comp_rvalid,
  output logic [63:0] comp_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wen,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
`ifdef MLACCEL_MEMARB_PERF_EN
  ,
  input  logic        perf_clear,
  output logic [15:0] perf_host_grants,
  output logic [15:0] perf_comp_grants,
  output logic [15:0] perf_comp_stalls
`endif
);

  localparam logic [3:0] BURST_MAX = 4'(COMP_BURST);

  typedef struct packed {
    logic valid;
    logic comp;
    logic read;
  } tag_t;

  logic       host_busy;
  logic [3:0] burst_cnt;
  logic       host_pend;
  logic       host_gnt;
  logic       comp_gnt;
  tag_t       tag_issue;
  tag_t       tag_mem;

  // Grant selection: compute wins a contended cycle until its burst allowance is used up.
  always_comb begin
    host_pend = (host_read | host_write) & ~host_busy & ~host_done;
    host_gnt  = 1'b0;
    comp_gnt  = 1'b0;
    if (comp_valid && (!host_pend || (burst_cnt < BURST_MAX))) begin
      comp_gnt = 1'b1;
    end else if (host_pend) begin
      host_gnt = 1'b1;
    end else begin
      comp_gnt = 1'b0;
    end
  end

  assign comp_ready = comp_gnt & ~reset;

  // Memory command registers, tag pipeline, response capture and arbitration state.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr    <= 16'h0000;
      mem_wen     <= 8'h00;
      mem_wdata   <= 64'h0;
      tag_issue   <= '0;
      tag_mem     <= '0;
      host_done   <= 1'b0;
      comp_rvalid <= 1'b0;
      host_rdata  <= 64'h0;
      comp_rdata  <= 64'h0;
      host_busy   <= 1'b0;
      burst_cnt   <= 4'd0;
    end else begin
      if (host_gnt) begin
        mem_addr  <= host_addr;
        mem_wen   <= host_write ? host_wtags : 8'h00;
        mem_wdata <= host_wdata;
      end else if (comp_gnt) begin
        mem_addr  <= comp_addr;
        mem_wen   <= comp_write ? comp_wen : 8'h00;
        mem_wdata <= comp_wdata;
      end else begin
        mem_wen   <= 8'h00;
      end

      tag_issue.valid <= host_gnt | comp_gnt;
      tag_issue.comp  <= comp_gnt;
      tag_issue.read  <= host_gnt ? host_read : ~comp_write;
      tag_mem         <= tag_issue;

      // tag_mem describes the access whose data is on mem_rdata this cycle
      host_done   <= tag_mem.valid & ~tag_mem.comp;
      comp_rvalid <= tag_mem.valid & tag_mem.comp & tag_mem.read;
      if (tag_mem.valid && !tag_mem.comp && tag_mem.read) begin
        host_rdata <= mem_rdata;
      end else begin
        host_rdata <= host_rdata;
      end
      if (tag_mem.valid && tag_mem.comp && tag_mem.read) begin
        comp_rdata <= mem_rdata;
      end else begin
        comp_rdata <= comp_rdata;
      end

      if (host_gnt) begin
        host_busy <= 1'b1;
      end else if (host_done) begin
        host_busy <= 1'b0;
      end else begin
        host_busy <= host_busy;
      end

      if (host_gnt || !host_pend) begin
        burst_cnt <= 4'd0;
      end else if (comp_gnt) begin
        burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= burst_cnt;
      end
    end
  end

`ifdef MLACCEL_MEMARB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    if (en && (cnt != 16'hFFFF)) begin
      return cnt + 16'd1;
    end else begin
      return cnt;
    end
  endfunction

  // Saturating grant and stall counters.
  always_ff @(posedge clock) begin
    if (reset || perf_clear) begin
      perf_host_grants <= 16'h0000;
      perf_comp_grants <= 16'h0000;
      perf_comp_stalls <= 16'h0000;
    end else begin
      perf_host_grants <= sat_inc(perf_host_grants, host_gnt);
      perf_comp_grants <= sat_inc(perf_comp_grants, comp_gnt);
      perf_comp_stalls <= sat_inc(perf_comp_stalls, comp_valid & ~comp_ready);
    end
  end
`endif

endmodule

// File: doc/mlaccel_memarb.md
Name: mlaccel_memarb

Overview:
- Arbitrates the single-port 64-bit main memory (16-bit word address, 8 byte-lane write enables) between two requesters.
- Host requester: the QPI command engine. It uses a level-held read/write request and is acknowledged by a done pulse.
- Compute requester: the compute sequencer. It uses a pipelined valid/ready request channel with a separate read-response strobe.
- The block sits between the command state machine and mlaccel_memory, replacing the direct qmem-to-memory wiring.

Parameters:
- COMP_BURST, 4: maximum consecutive compute grants while a host request is waiting. Legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- host_read  in  1  host read request; level-held until host_done
- host_write  in  1  host write request; level-held until host_done; never asserted together with host_read
- host_addr  in  16  host word address
- host_wdata  in  64  host write data
- host_wtags  in  8  host byte-lane write enables
- host_done  out  1  one-cycle completion pulse
- host_rdata  out  64  host read data; valid from the host_done cycle, held until the next host read completes
- comp_valid  in  1  compute request valid
- comp_ready  out  1  compute request accepted this cycle (combinational)
- comp_write  in  1  1 = write, 0 = read
- comp_addr  in  16  compute word address
- comp_wdata  in  64  compute write data
- comp_wen  in  8  compute byte-lane write enables
- comp_rvalid  out  1  compute read-data strobe
- comp_rdata  out  64  compute read data; valid with comp_rvalid
- mem_addr  out  16  memory address (registered)
- mem_wen  out  8  memory byte write enables (registered); 0 on reads and idle cycles
- mem_wdata  out  64  memory write data (registered)
- mem_rdata  in  64  memory read data; valid one cycle after the address cycle

Behaviour:
- Reset values: host_done=0, comp_rvalid=0, mem_wen=0, mem_addr=0, mem_wdata=0, host_rdata=0, comp_rdata=0. Reset also clears host_busy, the burst counter and the in-flight pipeline.
- host_pend = (host_read|host_write) & !host_busy & !host_done.
- Arbitration runs every cycle, at most one grant per cycle:
  - Only host_pend: grant host.
  - Only comp_valid: grant compute.
  - Both: grant compute while burst_cnt < COMP_BURST, otherwise grant host.
  - burst_cnt increments on each compute grant made while host_pend=1. It clears on a host grant, and when host_pend=0.
- comp_ready = comp_valid & compute granted & !reset.
- Host grant sets host_busy. host_busy clears on the host_done cycle.
- Grant in cycle t:
  - Registers mem_addr/mem_wen/mem_wdata at the end of t; mem_wen = write ? enables : 0.
  - Pushes tag {requester, is_read} into a 2-stage pipeline.
- Memory latches during t+1. mem_rdata is registered at the end of t+2 into the tagged destination.
- Responses in cycle t+3:
  - host_done pulses for both reads and writes; host_rdata is updated for reads only.
  - comp_rvalid pulses for compute reads only. Compute writes produce no response.
- Host latency: grant to done is 3 cycles.
- Compute throughput: one access per cycle. Back-to-back reads give back-to-back comp_rvalid, in issue order.
- Idle cycle with no grant: mem_wen=0. mem_addr and mem_wdata hold their previous values.
- Host write with host_wtags=0 is still an access; done pulses normally.
- The host must drop its request the cycle after host_done. host_pend masks the request during the done cycle, so no double grant occurs.
- Simultaneous host grant completion and new compute request: independent, no stall.
- Reset mid-operation: in-flight responses are discarded, with no done or rvalid pulse. The first grant can occur in the cycle after reset deasserts.

Optional Feature:
- Macro MLACCEL_MEMARB_PERF_EN.
- Defined: adds outputs perf_host_grants[15:0], perf_comp_grants[15:0] and perf_comp_stalls[15:0].
  - perf_comp_stalls counts cycles with comp_valid & !comp_ready.
  - All three are saturating at FFFFh and cleared by reset.
  - Adds input perf_clear, which zeroes all three synchronously.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Host write only: addr 0010h, wdata 0123456789ABCDEFh, wtags FFh. Expect mem_wen=FFh for exactly one cycle and host_done exactly 3 cycles after grant. A following host read of 0010h returns 0123456789ABCDEFh in host_rdata on host_done.
- Compute read burst: 8 back-to-back reads at addr 0..7 with comp_valid held. Expect comp_ready every cycle and 8 consecutive comp_rvalid pulses in address order, first at grant+3.
- Contention: comp_valid held continuously plus host_read asserted, COMP_BURST=4. Expect exactly 4 compute grants, then 1 host grant, then compute resumes. host_done occurs within 4+3 cycles of the request.
- Partial write: compute write of AAh to all lanes with comp_wen=0Fh over an FFh-filled word. A read then returns FFFFFFFFAAAAAAAAh.
- Reset mid-operation: assert reset the cycle after a host grant. Expect no host_done, mem_wen=0, and a fresh host request served normally after reset.
- With MLACCEL_MEMARB_PERF_EN: run the contention scenario for 20 cycles. Expect perf_comp_stalls equal to the number of host-grant cycles, and zero after perf_clear.
